// File: rtl/switch_debounce_display_if.sv
// Board-side switch/LED/7-segment bundle between the pins and the debounce/display block.
interface switch_debounce_display_if #(
    parameter int unsigned CHANNELS = 6
);
    logic [CHANNELS-1:0]   SW;
    logic                  MODE;
    logic                  CLEAR;
    logic [CHANNELS-1:0]   LEDR;
    logic [8*CHANNELS-1:0] HEX;
    logic [CHANNELS-1:0]   EDGE;

    modport master (output SW, MODE, CLEAR, input LEDR, HEX, EDGE);
    modport slave  (input SW, MODE, CLEAR, output LEDR, HEX, EDGE);
endinterface

// File: rtl/switch_debounce_display.sv
// Per-channel switch synchroniser + debouncer with LED, rising-edge pulse,
// 4-bit edge counter and a registered 7-segment digit (state or count).
module switch_debounce_display #(
    parameter int unsigned CHANNELS        = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    switch_debounce_display_if.slave bus
);
    localparam int unsigned CW          = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST      = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]    SEG_ZERO  = 8'hC0;

    logic [CHANNELS-1:0]   s1;
    logic [CHANNELS-1:0]   s2;
    logic [CHANNELS-1:0]   stable;
    logic [CW-1:0]         cnt   [CHANNELS];
    logic [3:0]            count [CHANNELS];
    logic [CHANNELS-1:0]   edge_q;
    logic [8*CHANNELS-1:0] hex_q;

    logic [CHANNELS-1:0]   settle_c;
    logic [CHANNELS-1:0]   rise_c;

    // Active-low segment pattern for one hex digit; bit 7 (decimal point) stays off.
    function automatic logic [7:0] seg7(input logic [3:0] v);
        seg7 = 8'hFF;
        case (v)
            4'h0: seg7 = 8'hC0;
            4'h1: seg7 = 8'hF9;
            4'h2: seg7 = 8'hA4;
            4'h3: seg7 = 8'hB0;
            4'h4: seg7 = 8'h99;
            4'h5: seg7 = 8'h92;
            4'h6: seg7 = 8'h82;
            4'h7: seg7 = 8'hF8;
            4'h8: seg7 = 8'h80;
            4'h9: seg7 = 8'h90;
            4'hA: seg7 = 8'h88;
            4'hB: seg7 = 8'h83;
            4'hC: seg7 = 8'hC6;
            4'hD: seg7 = 8'hA1;
            4'hE: seg7 = 8'h86;
            4'hF: seg7 = 8'h8E;
        endcase
    endfunction

    // A channel settles when its synchronised input has disagreed for the full window.
    always_comb begin
        settle_c = '0;
        rise_c   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            settle_c[i] = (s2[i] != stable[i]) && (cnt[i] == LAST);
            rise_c[i]   = settle_c[i] && s2[i];
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            edge_q <= '0;
            hex_q  <= {CHANNELS{SEG_ZERO}};
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]   <= '0;
                count[i] <= '0;
            end
        end else begin
            s1     <= bus.SW;
            s2     <= s1;
            edge_q <= rise_c;
            for (int i = 0; i < CHANNELS; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (settle_c[i]) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end

                // Clear wins over a coincident rising edge; the pulse still goes out.
                if (bus.CLEAR) begin
                    count[i] <= '0;
                end else if (rise_c[i]) begin
                    count[i] <= count[i] + 4'(1);
                end

                hex_q[8*i +: 8] <= seg7(bus.MODE ? count[i] : {3'b000, stable[i]});
            end
        end
    end

    assign bus.LEDR = stable;
    assign bus.EDGE = edge_q;
    assign bus.HEX  = hex_q;

endmodule

// File: tb/tb_switch_debounce_display.sv
// Bench for switch_debounce_display: directed scenarios plus randomized traffic
// checked against a window-based reference model.
module tb_switch_debounce_display;
    localparam int unsigned CH = 6;
    localparam int unsigned DB = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    switch_debounce_display_if #(.CHANNELS(CH)) bus ();

    switch_debounce_display #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DB)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seg(input logic [3:0] v);
        logic [7:0] t [16];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[v];
    endfunction

    // Reference model: a channel flips once its synchronised input (raw SW two
    // edges late) has disagreed with the accepted state on the last DB edges.
    logic [DB:0][CH-1:0]   hist;
    logic [CH-1:0]         m_stable;
    logic [CH-1:0]         m_edge;
    logic [CH-1:0][3:0]    m_count;
    logic [8*CH-1:0]       m_hex;

    function automatic logic [CH-1:0] flip_mask(input logic [DB:0][CH-1:0] h,
                                                input logic [CH-1:0] st);
        logic [CH-1:0] m = '1;
        for (int k = 1; k <= DB; k++) m &= h[k] ^ st;
        return m;
    endfunction

    function automatic logic [CH-1:0][3:0] next_count(input logic [CH-1:0][3:0] c,
                                                      input logic [CH-1:0] rise,
                                                      input logic clr);
        logic [CH-1:0][3:0] r = c;
        for (int i = 0; i < CH; i++) begin
            if (clr) r[i] = 4'd0;
            else if (rise[i]) r[i] = 4'((int'(c[i]) + 1) % 16);
        end
        return r;
    endfunction

    function automatic logic [8*CH-1:0] hex_of(input logic [CH-1:0][3:0] c,
                                               input logic [CH-1:0] st,
                                               input logic md);
        logic [8*CH-1:0] r = '0;
        for (int i = 0; i < CH; i++) r[8*i +: 8] = seg(md ? c[i] : {3'b000, st[i]});
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist     <= '0;
            m_stable <= '0;
            m_edge   <= '0;
            m_count  <= '0;
            m_hex    <= {CH{8'hC0}};
        end else begin
            hist     <= {hist[DB-1:0], bus.SW};
            m_stable <= m_stable ^ flip_mask(hist, m_stable);
            m_edge   <= flip_mask(hist, m_stable) & ~m_stable;
            m_count  <= next_count(m_count, flip_mask(hist, m_stable) & ~m_stable, bus.CLEAR);
            m_hex    <= hex_of(m_count, m_stable, bus.MODE);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [CH-1:0]   e_led;
        logic [CH-1:0]   e_edge;
        logic [8*CH-1:0] e_hex;
        bus.SW = '1; bus.MODE = 1'b0; bus.CLEAR = 1'b0; rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.LEDR !== '0 || bus.EDGE !== '0 || bus.HEX !== {CH{8'hC0}}) begin
                failures++;
                $display("FAIL reset_hold: ledr=%h edge=%h hex=%h expected 0/0/all C0", bus.LEDR, bus.EDGE, bus.HEX);
            end
        end
        rst = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            e_led  = (n >= 6) ? 6'h3F : 6'h00;
            e_edge = (n == 6) ? 6'h3F : 6'h00;
            e_hex  = (n >= 7) ? {CH{8'hF9}} : {CH{8'hC0}};
            checks++;
            if (bus.LEDR !== e_led || bus.EDGE !== e_edge || bus.HEX !== e_hex) begin
                failures++;
                $display("FAIL reset_release n=%0d: ledr=%h edge=%h hex=%h expected %h/%h/%h",
                         n, bus.LEDR, bus.EDGE, bus.HEX, e_led, e_edge, e_hex);
            end
        end
        bus.SW = '0;
        tick(10);
    endtask

    task automatic test_single_edge();
        bus.SW[0] = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            checks++;
            if (bus.LEDR[0] !== (n >= 6) || bus.EDGE[0] !== (n == 6) ||
                bus.HEX[7:0] !== ((n >= 7) ? 8'hF9 : 8'hC0)) begin
                failures++;
                $display("FAIL single_edge n=%0d: ledr0=%b edge0=%b hex0=%h", n, bus.LEDR[0], bus.EDGE[0], bus.HEX[7:0]);
            end
        end
        bus.SW[0] = 1'b0;
        tick(3);
        bus.SW[0] = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            checks++;
            if (bus.LEDR !== 6'h01 || bus.EDGE !== '0 || bus.HEX[7:0] !== 8'hF9) begin
                failures++;
                $display("FAIL glitch n=%0d: ledr=%h edge=%h hex0=%h expected 01/00/F9", n, bus.LEDR, bus.EDGE, bus.HEX[7:0]);
            end
        end
        bus.SW[0] = 1'b0;
        tick(10);
    endtask

    task automatic test_wrap();
        int pulses = 0;
        bus.MODE = 1'b1; bus.CLEAR = 1'b1;
        tick(1);
        bus.CLEAR = 1'b0;
        tick(1);
        checks++;
        if (bus.HEX !== {CH{8'hC0}}) begin
            failures++;
            $display("FAIL clear_all: hex=%h expected all C0", bus.HEX);
        end
        for (int r = 1; r <= 17; r++) begin
            bus.SW[2] = 1'b1;
            repeat (8) begin @(negedge clk); pulses += int'(bus.EDGE[2]); end
            checks++;
            if (bus.HEX[23:16] !== seg(4'(r % 16))) begin
                failures++;
                $display("FAIL wrap_digit r=%0d: hex2=%h expected %h", r, bus.HEX[23:16], seg(4'(r % 16)));
            end
            bus.SW[2] = 1'b0;
            repeat (8) begin @(negedge clk); pulses += int'(bus.EDGE[2]); end
        end
        checks++;
        if (pulses != 17 || bus.HEX[23:16] !== 8'hF9) begin
            failures++;
            $display("FAIL wrap_total: pulses=%0d hex2=%h expected 17/F9", pulses, bus.HEX[23:16]);
        end
    endtask

    task automatic test_clear_edge();
        bus.SW[3] = 1'b1; tick(8);
        bus.SW[3] = 1'b0; tick(8);
        checks++;
        if (bus.HEX[31:24] !== 8'hF9) begin
            failures++;
            $display("FAIL clear_pre: hex3=%h expected F9", bus.HEX[31:24]);
        end
        bus.SW[3] = 1'b1;
        tick(5);
        bus.CLEAR = 1'b1;
        tick(1);
        bus.CLEAR = 1'b0;
        checks++;
        if (bus.EDGE !== 6'h08 || bus.LEDR[3] !== 1'b1) begin
            failures++;
            $display("FAIL clear_pulse: edge=%h ledr3=%b expected 08/1", bus.EDGE, bus.LEDR[3]);
        end
        tick(1);
        checks++;
        if (bus.HEX[31:24] !== 8'hC0 || bus.HEX[23:16] !== 8'hC0) begin
            failures++;
            $display("FAIL clear_wins: hex3=%h hex2=%h expected C0/C0", bus.HEX[31:24], bus.HEX[23:16]);
        end
        bus.SW[3] = 1'b0;
        tick(8);
    endtask

    task automatic test_reset_mid();
        bus.SW = 6'b100000;
        tick(4);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.LEDR !== '0 || bus.EDGE !== '0 || bus.HEX !== {CH{8'hC0}}) begin
            failures++;
            $display("FAIL reset_async: ledr=%h edge=%h hex=%h expected 0/0/all C0", bus.LEDR, bus.EDGE, bus.HEX);
        end
        tick(2);
        rst = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            checks++;
            if (bus.LEDR !== ((n >= 6) ? 6'h20 : 6'h00) || bus.EDGE !== ((n == 6) ? 6'h20 : 6'h00)) begin
                failures++;
                $display("FAIL reset_mid n=%0d: ledr=%h edge=%h", n, bus.LEDR, bus.EDGE);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus.SW[1] = 1'b1; bus.SW[4] = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            checks++;
            if (bus.EDGE !== ((n == 6) ? 6'b010010 : 6'b000000) ||
                bus.LEDR !== ((n >= 6) ? 6'b110010 : 6'b100000)) begin
                failures++;
                $display("FAIL simultaneous n=%0d: edge=%h ledr=%h", n, bus.EDGE, bus.LEDR);
            end
        end
        checks++;
        if (bus.HEX !== {8'hF9, 8'hF9, 8'hC0, 8'hC0, 8'hF9, 8'hC0}) begin
            failures++;
            $display("FAIL simultaneous_hex: hex=%h expected F9F9C0C0F9C0", bus.HEX);
        end
    endtask

    task automatic test_random();
        int hold;
        for (int seg_i = 0; seg_i < 200; seg_i++) begin
            bus.SW    = CH'($urandom);
            bus.MODE  = 1'($urandom);
            bus.CLEAR = ($urandom_range(0, 7) == 0);
            hold = $urandom_range(1, 10);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                bus.CLEAR = 1'b0;
                checks++;
                if (bus.LEDR !== m_stable || bus.EDGE !== m_edge || bus.HEX !== m_hex) begin
                    failures++;
                    $display("FAIL random seg=%0d: ledr=%h edge=%h hex=%h expected %h/%h/%h",
                             seg_i, bus.LEDR, bus.EDGE, bus.HEX, m_stable, m_edge, m_hex);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.SW = '0; bus.MODE = 1'b0; bus.CLEAR = 1'b0;
        test_reset();
        test_single_edge();
        test_wrap();
        test_clear_edge();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
